alu_muldiv_ctrl: RTL and testbench
==================================

Name: alu_muldiv_ctrl

Overview:
Parametrised successor to the single-cycle ALU controller for the multi-cycle MIPS datapath. It keeps the combinational func/ALUOp decode to the 3-bit ALU operation code, and adds a sequential multiply/divide engine. The engine is started by R-type MULTU/DIVU and writes the HI/LO registers. It sits beside the main ALU. The control unit uses `stall`/`done` to hold the PC while an iterative operation runs.

Parameters:
- WIDTH, 32, operand/HI/LO width; legal values are ≥4 and even.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ALU_in  input  2  ALUOp from the main controller.
- func  input  6  instruction funct field.
- start  input  1  instruction-issue strobe, sampled on the rising edge.
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- ALU_operation  output  3  combinational ALU op code.
- busy  output  1  high while an iteration is in progress.
- done  output  1  one-cycle completion pulse.
- stall  output  1  combinational hold request to the control unit.
- hi  output  WIDTH  HI register (product high half / remainder).
- lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Decode (combinational):
  - ALU_in=00 → 010 (add).
  - ALU_in=01 → 011 (sub).
  - ALU_in=11 → 011.
  - ALU_in=10 decodes func:
    - 100000 → 010.
    - 100010 → 011.
    - 100100 → 000.
    - 100101 → 001.
    - 101010 → 111 (slt).
    - any other func → 011.
- Mul/div funcs (valid only when ALU_in=10): MULTU=011001, DIVU=011011. ALU_operation is 011 for these; the main ALU result is ignored.
- `is_md` = (ALU_in==10) and func ∈ {MULTU, DIVU}.
- FSM states: IDLE, RUN, FIN.
  - IDLE/FIN, start & is_md:
    - Latch a, b and the op.
    - Clear counter; clear the partial accumulator.
    - Go to RUN.
  - IDLE/FIN, otherwise: go to IDLE.
  - RUN: one bit per cycle.
    - MULTU: shift-add, LSB of multiplier first.
    - DIVU: restoring division, MSB of dividend first.
    - Counter increments each cycle.
    - When counter==WIDTH-1: write hi/lo, go to FIN.
  - FIN: done=1 for exactly one cycle.
- DIVU with b==0:
  - Accepting edge goes straight to FIN.
  - lo = all ones, hi = a.
  - done pulses on the next cycle.
- Latency:
  - Start accepted at edge T.
  - busy=1 for cycles T+1 … T+WIDTH.
  - hi/lo update at edge T+WIDTH.
  - done=1 during cycle T+WIDTH+1.
- busy = (state==RUN).
- stall = busy | (start & is_md & state≠RUN). The issuing cycle stalls; the FIN cycle does not stall.
- start while in RUN is ignored; it is neither queued nor latched.
- A new start in FIN is accepted: back-to-back operations are allowed, and done still pulses for the completed op.
- hi/lo hold their value until the next completion; non-md starts never modify them.
- MULTU: {hi,lo} = a*b, exact 2·WIDTH-bit unsigned product.
- DIVU: lo = a/b, hi = a%b, unsigned.
- Reset (any state, including mid-RUN): state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, latched operands=0. An in-flight result is discarded.

Optional Feature:
SIGNED_MULDIV_EN
- Defined: also decodes MULT=011000 and DIV=011010 as `is_md`.
  - Operands are converted to magnitudes at acceptance; the sign is fixed up at the writing edge; latency is unchanged.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - DIV by zero behaves as DIVU by zero.
  - Most-negative ÷ −1: lo = most-negative, hi=0.
- Undefined: 011000/011010 fall into default decode (011), do not start, and do not stall.

Test Plan:
- Decode sweep: all ALU_in values and each listed func, plus func=111111 → ALU_operation 010, 011, 000, 001, 111, 011 as specified.
- MULTU, WIDTH=32, a=0xFFFFFFFF, b=2, start at edge T:
  - hi=0x00000001, lo=0xFFFFFFFE at edge T+32.
  - done only in cycle T+33.
  - busy high for 32 cycles.
- DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=5, b=0 → done one cycle after acceptance, lo=0xFFFFFFFF, hi=5.
- start (MULTU a=3, b=4) asserted during RUN of DIVU 100/7 → ignored; result 14/2 only. Then a start in the FIN cycle is accepted: lo=12, hi=0 after 32 more cycles.
- rst pulsed mid-RUN (counter=10):
  - Next cycle: busy=0, hi=lo=0, no done pulse.
  - A subsequent MULTU 6×7 gives lo=42.
- SIGNED_MULDIV_EN:
  - DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - MULT −3×4 → hi=0xFFFFFFFF, lo=0xFFFFFFF4.
  - With the macro undefined, the same func gives no stall and no done.

Source files
------------

// File: rtl/alu_muldiv_ctrl.sv
// rtl/alu_muldiv_ctrl.sv - ALU op decode plus iterative MULTU/DIVU engine writing HI/LO (optional macro: SIGNED_MULDIV_EN)
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ALU_in,
  input  logic [5:0]       func,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       ALU_operation,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
`ifdef SIGNED_MULDIV_EN
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] opb_q;   // multiplicand or divisor (magnitude)
  logic [WIDTH-1:0] acc_q;   // partial product high half / partial remainder
  logic [WIDTH-1:0] quo_q;   // multiplier bits shifting out / dividend in, quotient out
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
`ifdef SIGNED_MULDIV_EN
  logic             neg_q;      // quotient/product must be negated at the writing edge
  logic             rem_neg_q;  // remainder takes the dividend's sign
  logic             is_sgn;
`endif

  logic             is_mul;
  logic             is_div;
  logic             is_md;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] fin_hi;
  logic [WIDTH-1:0] fin_lo;

  // Main-ALU operation decode from ALUOp and funct
  always_comb begin
    ALU_operation = 3'b011;
    case (ALU_in)
      2'b00: ALU_operation = 3'b010;
      2'b10: begin
        case (func)
          FN_ADD:  ALU_operation = 3'b010;
          FN_SUB:  ALU_operation = 3'b011;
          FN_AND:  ALU_operation = 3'b000;
          FN_OR:   ALU_operation = 3'b001;
          FN_SLT:  ALU_operation = 3'b111;
          default: ALU_operation = 3'b011;
        endcase
      end
      default: ALU_operation = 3'b011;
    endcase
  end

  // Classify the issuing instruction as a multiply or divide start candidate
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
`ifdef SIGNED_MULDIV_EN
    is_sgn = 1'b0;
`endif
    if (ALU_in == 2'b10) begin
      case (func)
        FN_MULTU: is_mul = 1'b1;
        FN_DIVU:  is_div = 1'b1;
`ifdef SIGNED_MULDIV_EN
        FN_MULT: begin
          is_mul = 1'b1;
          is_sgn = 1'b1;
        end
        FN_DIV: begin
          is_div = 1'b1;
          is_sgn = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign is_md = is_mul | is_div;

  // The iteration always works on magnitudes; signed ops strip signs here
`ifdef SIGNED_MULDIV_EN
  assign a_mag = (is_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_sgn && b[WIDTH-1]) ? -b : b;
`else
  assign a_mag = a;
  assign b_mag = b;
`endif

  // One iteration: shift-add multiply (LSB first) or restoring divide (MSB first)
  always_comb begin
    addend  = quo_q[0] ? opb_q : '0;
    add_sum = {1'b0, acc_q} + {1'b0, addend};
    shifted = {acc_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opb_q};
    if (is_div_q) begin
      if (diff[WIDTH]) begin
        acc_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_d = add_sum[WIDTH:1];
      quo_d = {add_sum[0], quo_q[WIDTH-1:1]};
    end
  end

`ifdef SIGNED_MULDIV_EN
  logic [2*WIDTH-1:0] prod_neg;

  // Sign fix-up applied to the final iteration's result
  always_comb begin
    prod_neg = -{acc_d, quo_d};
    fin_hi   = acc_d;
    fin_lo   = quo_d;
    if (is_div_q) begin
      if (neg_q)     fin_lo = -quo_d;
      if (rem_neg_q) fin_hi = -acc_d;
    end else if (neg_q) begin
      fin_hi = prod_neg[2*WIDTH-1:WIDTH];
      fin_lo = prod_neg[WIDTH-1:0];
    end
  end
`else
  assign fin_hi = acc_d;
  assign fin_lo = quo_d;
`endif

  // Engine FSM: accept in IDLE/FIN, iterate in RUN, pulse done in FIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef SIGNED_MULDIV_EN
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          acc_q <= acc_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            hi_q    <= fin_hi;
            lo_q    <= fin_lo;
            done_q  <= 1'b1;
            state_q <= FIN;
          end
        end
        default: begin
          if (start && is_md) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            is_div_q <= is_div;
            opb_q    <= is_div ? b_mag : a_mag;
            quo_q    <= is_div ? a_mag : b_mag;
`ifdef SIGNED_MULDIV_EN
            neg_q     <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_q <= is_sgn & is_div & a[WIDTH-1];
`endif
            if (is_div && (b == '0)) begin
              // Divide by zero needs no iterations: the result is known now
              hi_q    <= a;
              lo_q    <= '1;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              state_q <= RUN;
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = done_q;
  assign stall = busy | (start & is_md & (state_q != RUN));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb/tb_alu_muldiv_ctrl.sv - randomized model-checked bench for alu_muldiv_ctrl with directed literal pins
module tb_alu_muldiv_ctrl;
  localparam int W = 32;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  alu_in;
  logic [5:0]  func;
  logic [31:0] a, b;
  logic [2:0]  alu_op;
  logic        busy, done, stall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_done = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .ALU_in(alu_in), .func(func), .start(start),
    .a(a), .b(b), .ALU_operation(alu_op), .busy(busy), .done(done),
    .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_dec(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 3'b010;
    if (op != 2'b10) return 3'b011;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b011;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b011;
    endcase
  endfunction

  // 0 none, 1 MULTU, 2 DIVU, 3 MULT, 4 DIV
  function automatic int md_kind(input logic [1:0] op, input logic [5:0] fn);
    if (op != 2'b10) return 0;
    if (fn == F_MULTU) return 1;
    if (fn == F_DIVU) return 2;
`ifdef SIGNED_MULDIV_EN
    if (fn == F_MULT) return 3;
    if (fn == F_DIV) return 4;
`endif
    return 0;
  endfunction

  // Reference: countdown of remaining busy cycles, result computed with plain arithmetic
  always @(posedge clk) begin
    int k;
    longint sa, sb, q, r;
    logic [63:0] p;
    m_done = 1'b0;
    k = md_kind(alu_in, func);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (rst) begin
      m_left = 0;
      m_hi = '0;
      m_lo = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
        m_done = 1'b1;
      end
    end else if (start && k != 0) begin
      if ((k == 2 || k == 4) && b == 32'd0) begin
        m_hi = a;
        m_lo = 32'hFFFF_FFFF;
        m_done = 1'b1;
      end else begin
        case (k)
          1: begin
            p = 64'(a) * 64'(b);
            p_hi = p[63:32];
            p_lo = p[31:0];
          end
          2: begin
            p_lo = a / b;
            p_hi = a % b;
          end
          3: begin
            p = sa * sb;
            p_hi = p[63:32];
            p_lo = p[31:0];
          end
          default: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              p_lo = a;
              p_hi = 32'd0;
            end else begin
              q = sa / sb;
              r = sa % sb;
              p_lo = q[31:0];
              p_hi = r[31:0];
            end
          end
        endcase
        m_left = W;
      end
    end
  end

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    if (chk_en) begin
      chk("alu_op", 64'(alu_op), 64'(ref_dec(alu_in, func)));
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("stall", 64'(stall), 64'((m_left > 0) || (start && md_kind(alu_in, func) != 0)));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic idle();
    start = 1'b0;
    alu_in = 2'b00;
    func = 6'd0;
  endtask

  task automatic issue_observe(input logic [5:0] fn, input logic [31:0] ia, input logic [31:0] ib,
                               input int n, output logic st, output int busy_n, output int done_n,
                               output int done_k, output logic [31:0] hi_at, output logic [31:0] lo_at);
    start = 1'b1;
    alu_in = 2'b10;
    func = fn;
    a = ia;
    b = ib;
    @(negedge clk);
    st = stall;
    @(posedge clk);
    #1;
    idle();
    busy_n = 0;
    done_n = 0;
    done_k = 0;
    hi_at = hi;
    lo_at = lo;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k == 0) begin
          done_k = k;
          hi_at = hi;
          lo_at = lo;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic dchk(input string name, input logic [1:0] op, input logic [5:0] fn, input logic [2:0] exp);
    idle();
    alu_in = op;
    func = fn;
    @(negedge clk);
    chk(name, 64'(alu_op), 64'(exp));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return 32'($urandom_range(0, 15));
      2: return 32'd0;
      3: return 32'hFFFF_FFFF;
      default: return 32'h8000_0000;
    endcase
  endfunction

  initial begin
    logic st;
    int bn, dn, dk;
    logic [31:0] h, l;
    logic [5:0] fl [10];
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
           F_MULTU, F_DIVU, F_MULT, F_DIV, 6'b111111};

    rst = 1'b1;
    idle();
    a = '0;
    b = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    dchk("dec_00", 2'b00, 6'b100010, 3'b010);
    dchk("dec_01", 2'b01, 6'b100000, 3'b011);
    dchk("dec_11", 2'b11, 6'b100100, 3'b011);
    dchk("dec_add", 2'b10, 6'b100000, 3'b010);
    dchk("dec_sub", 2'b10, 6'b100010, 3'b011);
    dchk("dec_and", 2'b10, 6'b100100, 3'b000);
    dchk("dec_or", 2'b10, 6'b100101, 3'b001);
    dchk("dec_slt", 2'b10, 6'b101010, 3'b111);
    dchk("dec_other", 2'b10, 6'b111111, 3'b011);
    dchk("dec_multu", 2'b10, F_MULTU, 3'b011);

    issue_observe(F_MULTU, 32'hFFFF_FFFF, 32'd2, 36, st, bn, dn, dk, h, l);
    chk("mul_stall_issue", 64'(st), 64'd1);
    chk("mul_busy_cycles", 64'(bn), 64'd32);
    chk("mul_done_cycle", 64'(dk), 64'd33);
    chk("mul_done_count", 64'(dn), 64'd1);
    chk("mul_hi", 64'(h), 64'h1);
    chk("mul_lo", 64'(l), 64'hFFFF_FFFE);

    issue_observe(F_DIVU, 32'd100, 32'd7, 36, st, bn, dn, dk, h, l);
    chk("div_lo", 64'(l), 64'd14);
    chk("div_hi", 64'(h), 64'd2);
    chk("div_done_cycle", 64'(dk), 64'd33);

    issue_observe(F_DIVU, 32'd5, 32'd0, 4, st, bn, dn, dk, h, l);
    chk("dz_done_cycle", 64'(dk), 64'd1);
    chk("dz_busy", 64'(bn), 64'd0);
    chk("dz_lo", 64'(l), 64'hFFFF_FFFF);
    chk("dz_hi", 64'(h), 64'd5);

    // Start during RUN is ignored; start in FIN is accepted
    start = 1'b1; alu_in = 2'b10; func = F_DIVU; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    idle();
    dn = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        if (dn == 1) begin
          chk("ign_done1_cycle", 64'(k), 64'd33);
          chk("ign_lo1", 64'(lo), 64'd14);
          chk("ign_hi1", 64'(hi), 64'd2);
        end else begin
          chk("b2b_done2_cycle", 64'(k), 64'd66);
          chk("b2b_lo2", 64'(lo), 64'd12);
          chk("b2b_hi2", 64'(hi), 64'd0);
        end
      end
      @(posedge clk);
      #1;
      if (k == 4 || k == 32) begin
        start = 1'b1; alu_in = 2'b10; func = F_MULTU; a = 32'd3; b = 32'd4;
      end else begin
        idle();
      end
    end
    chk("b2b_done_count", 64'(dn), 64'd2);

    // Reset mid-RUN while the counter is at 10
    start = 1'b1; alu_in = 2'b10; func = F_MULTU; a = 32'h1234_5678; b = 32'd9;
    @(posedge clk);
    #1;
    idle();
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_hi", 64'(hi), 64'd0);
    chk("mrst_lo", 64'(lo), 64'd0);
    dn = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (done) dn++;
    end
    chk("mrst_no_done", 64'(dn), 64'd0);
    @(posedge clk);
    #1;
    issue_observe(F_MULTU, 32'd6, 32'd7, 36, st, bn, dn, dk, h, l);
    chk("mul67_lo", 64'(l), 64'd42);
    chk("mul67_hi", 64'(h), 64'd0);

`ifdef SIGNED_MULDIV_EN
    issue_observe(F_DIV, 32'hFFFF_FFF9, 32'd2, 36, st, bn, dn, dk, h, l);
    chk("sdiv_lo", 64'(l), 64'hFFFF_FFFD);
    chk("sdiv_hi", 64'(h), 64'hFFFF_FFFF);
    chk("sdiv_done_cycle", 64'(dk), 64'd33);
    issue_observe(F_MULT, 32'hFFFF_FFFD, 32'd4, 36, st, bn, dn, dk, h, l);
    chk("smul_hi", 64'(h), 64'hFFFF_FFFF);
    chk("smul_lo", 64'(l), 64'hFFFF_FFF4);
`else
    issue_observe(F_DIV, 32'hFFFF_FFF9, 32'd2, 36, st, bn, dn, dk, h, l);
    chk("nosgn_stall", 64'(st), 64'd0);
    chk("nosgn_done", 64'(dn), 64'd0);
    chk("nosgn_busy", 64'(bn), 64'd0);
`endif

    // Randomized traffic checked every cycle by the reference
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 2) == 0);
      alu_in = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      func = fl[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) func = 6'($urandom);
      a = rnd_opnd();
      b = rnd_opnd();
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
